tile_row_packer: RTL
====================

# tile_row_packer

Upstream feeder for `data_4x4_transform`. It accepts a stream of 4-element rows over a valid/ready handshake and packs every four consecutive rows into one 16-element, 128-bit tile. Completed tiles sit in a two-slot ping-pong buffer until the downstream consumer takes them. The output is presented as a bit-exact `data` word for the transform stage.

## Interface
- `W`, default 8: element width in bits. Row width is 4·W; tile width is 16·W.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rstn`, in, 1: reset, asynchronous and active-low.
- `in_valid`, in, 1: `in_row` is valid this cycle.
- `in_ready`, out, 1: packer can accept a row this cycle.
- `in_row`, in, 4·W: one tile row; element 0 in bits [W-1:0].
- `in_sof`, in, 1: start of tile; qualifies the current row as row 0.
- `out_valid`, out, 1: `out_tile` holds a complete tile.
- `out_ready`, in, 1: consumer takes the tile this cycle.
- `out_tile`, out, 16·W: row r occupies bits [(r+1)·4W-1 : r·4W]; row 0 is in the LSBs.
- `err_sync`, out, 1: one-cycle pulse when a partial tile is discarded.
- `tile_cnt`, out, 16: count of tiles handed off (out_valid && out_ready); wraps 0xFFFF→0.

## Operation
- Handshakes:
  - A row is accepted when `in_valid && in_ready`.
  - A tile is handed off when `out_valid && out_ready`.
- State:
  - Two slots, each holding 4 row registers and a `full` flag.
  - `wr_sel` is the slot being filled; `rd_sel` is the slot being drained.
  - `row_cnt` counts 0..3.
- Accepted row:
  - The row is written into slot[`wr_sel`] at row index `row_cnt`, and `row_cnt` increments.
  - On the row with `row_cnt`==3: set full[`wr_sel`], toggle `wr_sel`, and set `row_cnt` to 0.
- Input ready: `in_ready` = !full[`wr_sel`]. It depends only on registered state; there is no combinational path from `out_ready`.
- Output: `out_valid` = full[`rd_sel`], and `out_tile` = slot[`rd_sel`] contents.
- On handoff: clear full[`rd_sel`], toggle `rd_sel`, and increment `tile_cnt`.
- Resync on `in_sof`:
  - An accepted row with `in_sof`=1 while `row_cnt`≠0 discards the partial rows.
  - That row is written as row 0, `row_cnt` becomes 1, and `err_sync` pulses for one cycle.
  - `in_sof` is ignored when `row_cnt`==0.
  - A stream without `in_sof` packs rows strictly in groups of four.
- Simultaneous events: completing one slot and handing off the other in the same cycle are independent and both take effect.
- Reset, asserted at any time, including mid-tile:
  - Both slots are cleared to 0, both full flags to 0.
  - `wr_sel`, `rd_sel`, and `row_cnt` go to 0.
  - Outputs: `in_ready`=1, `out_valid`=0, `out_tile`=0, `err_sync`=0, `tile_cnt`=0.
  - Partial rows are lost.

## Timing
- Latency: `out_valid` rises in the cycle after the 4th row is accepted, i.e. the first edge after acceptance.
- Throughput:
  - Sustained 1 row per cycle, giving 1 tile per 4 cycles while `out_ready` is high.
  - No bubbles between tiles.
- Backpressure:
  - With `out_ready` held low, exactly 8 rows are accepted, after which `in_ready` goes low.
  - `in_ready` returns high in the cycle after the first handoff.
- `out_tile` is stable while `out_valid`=1 and `out_ready`=0.
- Upstream rule: `in_row` and `in_sof` must be held while `in_valid`=1 and `in_ready`=0.
- `err_sync` is asserted in the cycle after the resyncing row's acceptance edge.

## Structure
- Shared package `tile_pkg`:
  - Defaults: `W`=8, `ROWS`=4, `COLS`=4.
  - Derived widths: `ROW_W`=COLS·W and `TILE_W`=ROWS·ROW_W.
  - A row-index type (2 bits).
  - The same package is used by `data_4x4_transform`.
- Sub-module `tile_slot`: one slot, containing 4 row registers, a full flag, a row write port (index, enable), a clear input, and a flattened tile output. `tile_row_packer` instantiates it twice.

## Test plan
- Single tile:
  - Stimulus: rows 0x01010101, 0x02020202, 0x03030303, 0x04040404 on consecutive cycles, with `in_sof` on the first row and `out_ready`=1.
  - Response: `out_tile`=128'h04040404030303030202020201010101, valid one cycle after the 4th accept; then `tile_cnt`=1.
- Back-to-back:
  - Stimulus: 3 tiles (12 rows) with no gaps and `out_ready`=1.
  - Response: 3 handoffs spaced 4 cycles apart, `in_ready` never low, `tile_cnt`=3.
- Backpressure:
  - Stimulus: `out_ready`=0 while driving 9 rows.
  - Response: `in_ready` drops after the 8th accept and the 9th row is held. On raising `out_ready`, tile A is handed off, then tile B, and the 9th row enters as row 0 of a new tile.
- Resync:
  - Stimulus: rows 0xAA.., 0xBB.., then 0x11111111 with `in_sof`=1, followed by 0x22.., 0x33.., 0x44...
  - Response: `err_sync` pulses once; the tile is 128'h44444444333333332222222211111111.
- Reset mid-operation:
  - Stimulus: deassert `rstn` after 2 rows of a tile, with one full tile pending.
  - Response: all outputs return to their reset values immediately. After release, a fresh 4-row tile emerges correctly and `tile_cnt` restarts from 0.

Source files
------------

// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared tile geometry for the row packer and the 4x4 transform
package tile_pkg;
  localparam int W      = 8;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int ROW_W  = COLS * W;
  localparam int TILE_W = ROWS * ROW_W;

  typedef logic [1:0] row_idx_t;
endpackage

// File: rtl/tile_row_packer_if.sv
// rtl/tile_row_packer_if.sv - row input stream and tile output stream of the packer
interface tile_row_packer_if
  import tile_pkg::*;
#(
  parameter int W = tile_pkg::W
);
  logic                      in_valid;
  logic                      in_ready;
  logic [COLS*W-1:0]         in_row;
  logic                      in_sof;
  logic                      out_valid;
  logic                      out_ready;
  logic [ROWS*COLS*W-1:0]    out_tile;

  modport master (
    output in_valid, in_row, in_sof, out_ready,
    input  in_ready, out_valid, out_tile
  );

  modport slave (
    input  in_valid, in_row, in_sof, out_ready,
    output in_ready, out_valid, out_tile
  );
endinterface

// File: rtl/tile_slot.sv
// rtl/tile_slot.sv - one ping-pong slot: four row registers and a full flag
module tile_slot
  import tile_pkg::*;
#(
  parameter int W = tile_pkg::W
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wr_en,
  input  row_idx_t               wr_idx,
  input  logic [COLS*W-1:0]      wr_row,
  input  logic                   set_full,
  input  logic                   clr,
  output logic                   full,
  output logic [ROWS*COLS*W-1:0] tile
);
  logic [ROWS-1:0][COLS*W-1:0] rows;

  assign tile = rows;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rows <= '0;
      full <= 1'b0;
    end else begin
      if (wr_en) begin
        rows[wr_idx] <= wr_row;
      end
      // a slot is never filled and drained in the same cycle, so order is moot
      if (set_full) begin
        full <= 1'b1;
      end else if (clr) begin
        full <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/tile_row_packer.sv
// rtl/tile_row_packer.sv - packs four accepted rows into one tile, double-buffered
module tile_row_packer
  import tile_pkg::*;
#(
  parameter int W = tile_pkg::W
) (
  input  logic              clk,
  input  logic              rstn,
  tile_row_packer_if.slave  bus,
  output logic              err_sync,
  output logic [15:0]       tile_cnt
);
  localparam int TW = ROWS * COLS * W;

  logic          full [2];
  logic [TW-1:0] tiles [2];
  logic          wr_sel;
  logic          rd_sel;
  row_idx_t      row_cnt;

  logic          in_ready_int;
  logic          accept;
  logic          handoff;
  logic          resync;
  logic          last_row;
  row_idx_t      wr_idx;

  // in_ready looks only at registered full flags, never at out_ready
  assign in_ready_int  = !full[wr_sel];
  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = full[rd_sel];
  assign bus.out_tile  = tiles[rd_sel];

  assign accept   = bus.in_valid && in_ready_int;
  assign handoff  = full[rd_sel] && bus.out_ready;
  assign resync   = accept && bus.in_sof && (row_cnt != '0);
  assign wr_idx   = resync ? '0 : row_cnt;
  assign last_row = accept && (wr_idx == row_idx_t'(ROWS - 1));

  for (genvar s = 0; s < 2; s++) begin : g_slot
    tile_slot #(.W(W)) u_slot (
      .clk      (clk),
      .rstn     (rstn),
      .wr_en    (accept && (wr_sel == 1'(s))),
      .wr_idx   (wr_idx),
      .wr_row   (bus.in_row),
      .set_full (last_row && (wr_sel == 1'(s))),
      .clr      (handoff && (rd_sel == 1'(s))),
      .full     (full[s]),
      .tile     (tiles[s])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      row_cnt  <= '0;
      err_sync <= 1'b0;
      tile_cnt <= '0;
    end else begin
      err_sync <= resync;
      if (accept) begin
        if (resync) begin
          row_cnt <= row_idx_t'(1);
        end else if (last_row) begin
          row_cnt <= '0;
        end else begin
          row_cnt <= row_cnt + row_idx_t'(1);
        end
      end
      if (last_row) begin
        wr_sel <= !wr_sel;
      end
      if (handoff) begin
        rd_sel   <= !rd_sel;
        tile_cnt <= tile_cnt + 16'd1;
      end
    end
  end
endmodule
